march_op_executor: RTL

Executes formatted single march operations against the memory under test. Sits directly downstream of the operation-formatting stage: it consumes one formatted op per handshake, drives the memory port, and sweeps the address counter up or down across one march element. It compares read data against the expected background, records the first failing address and counts fails.

---
 rtl/march_op_executor.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/march_op_executor.sv
// -----------------------------------------------------------------------------
// march_op_executor
//
// Executes formatted march operations against a memory under test. Each
// element starts with a start pulse. The pulse latches the sweep direction and
// the background pattern. The executor then accepts one op per handshake. For
// each accepted op it drives a registered memory access at the current
// address. A read is checked two edges after it is issued. The check compares
// the returned data against the expected background. The first failing address
// is recorded, and the fail count saturates at 255.
//
// Ports:
//   clk        in   1    clock, all state on rising edge
//   rst        in   1    asynchronous active-high reset
//   start      in   1    begin a march element (ignored while busy)
//   addr_down  in   1    sweep direction, sampled with start (1 = descending)
//   bg_data    in   dw   background pattern, sampled with start
//   op_in      in   opw  formatted op: [0] write, [1] invert bg, [2] last op
//   op_valid   in   1    op_in valid
//   op_ready   out  1    op accepted this cycle when op_valid is high
//   mem_addr   out  aw   registered memory address
//   mem_we     out  1    registered write strobe
//   mem_re     out  1    registered read strobe
//   mem_wdata  out  dw   registered write data (expected data for reads)
//   mem_rdata  in   dw   read data, valid the cycle after mem_re
//   busy       out  1    element in progress
//   elem_done  out  1    one-cycle pulse at element completion
//   fail       out  1    sticky read-mismatch flag
//   fail_addr  out  aw   address of the first mismatch
//   fail_cnt   out  8    saturating mismatch count
// -----------------------------------------------------------------------------
module march_op_executor #(
    parameter int opw = 3,
    parameter int aw  = 8,
    parameter int dw  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           addr_down,
    input  logic [dw-1:0]  bg_data,
    input  logic [opw-1:0] op_in,
    input  logic           op_valid,
    output logic           op_ready,
    output logic [aw-1:0]  mem_addr,
    output logic           mem_we,
    output logic           mem_re,
    output logic [dw-1:0]  mem_wdata,
    input  logic [dw-1:0]  mem_rdata,
    output logic           busy,
    output logic           elem_done,
    output logic           fail,
    output logic [aw-1:0]  fail_addr,
    output logic [7:0]     fail_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [aw-1:0] addr_max = '1;

    state_t          state;
    state_t          state_next;

    logic            dir_down;
    logic [dw-1:0]   bg;
    logic [aw-1:0]   cnt;
    logic            drain_step;

    // Second compare stage: the read issued one edge earlier, with its data due now.
    logic            cmp_valid;
    logic [dw-1:0]   cmp_exp;
    logic [aw-1:0]   cmp_addr;

    logic            handshake;
    logic            is_last;
    logic            at_end;
    logic            start_elem;
    logic            drain_done;
    logic            mismatch;
    logic [dw-1:0]   expected;

    // Ready and busy decode straight from the state register. They change on
    // the start edge and fall asynchronously with rst.
    assign op_ready  = (state == EXEC);
    assign busy      = (state != IDLE);
    assign handshake = op_valid && (state == EXEC);
    assign is_last   = op_in[2];
    assign expected  = bg ^ {dw{op_in[1]}};
    assign at_end    = dir_down ? (cnt == '0) : (cnt == addr_max);
    assign mismatch  = cmp_valid && (mem_rdata != cmp_exp);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next = state;
        start_elem = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_elem = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (handshake && is_last && at_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The compare pipeline is a fixed two stages deep. The second
                // DRAIN edge is therefore the edge on which the final read resolves.
                if (drain_step) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Element setup and address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_down   <= 1'b0;
            bg         <= '0;
            cnt        <= '0;
            drain_step <= 1'b0;
            elem_done  <= 1'b0;
        end else begin
            if (start_elem) begin
                dir_down <= addr_down;
                bg       <= bg_data;
                cnt      <= addr_down ? addr_max : '0;
            end else if (handshake && is_last && !at_end) begin
                // The counter stops at the end address rather than wrapping.
                cnt <= dir_down ? cnt - 1'b1 : cnt + 1'b1;
            end
            drain_step <= (state == DRAIN) && !drain_step;
            elem_done  <= drain_done;
        end
    end

    // Memory port. Address and data hold between accesses, and the strobes
    // drop in any cycle without a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (handshake) begin
                mem_addr  <= cnt;
                mem_we    <= op_in[0];
                mem_re    <= ~op_in[0];
                mem_wdata <= expected;
            end
        end
    end

    // Compare pipeline. mem_re, mem_addr and mem_wdata form the first stage.
    // The cmp_* registers form the second stage and line up with mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_cnt  <= '0;
        end else begin
            cmp_valid <= mem_re;
            cmp_exp   <= mem_wdata;
            cmp_addr  <= mem_addr;
            if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= cmp_addr;
                end
                if (fail_cnt != 8'hFF) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
            end
        end
    end

endmodule
